mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: start  in  1  E-stage request strobe, sampled each rising edge.
REQ-004 SHALL provide: op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-005 SHALL provide: a  in  32  forwarded rs operand.
REQ-006 SHALL provide: b  in  32  forwarded rt operand.
REQ-007 SHALL provide: cancel  in  1  exception/interrupt kill for the E-stage instruction in the same cycle.
REQ-008 SHALL provide: busy  out  1  registered; high while a mult/div is in flight; feeds the hazard stall (start||busy with D-stage MD).
REQ-009 SHALL provide: hi  out  32  registered HI value.
REQ-010 SHALL provide: lo  out  32  registered LO value.

Function
REQ-011 Accept = start & !cancel & !busy & !reset, evaluated at a rising edge.
REQ-012 Accept with op 0-3: latch a, b, op; load counter with 5 (mult) or 10 (div); busy = 1 from the next cycle.
REQ-013 busy SHALL stay high for exactly N cycles after the accept edge (N=5 mult, N=10 div); the counter decrements once per cycle.
REQ-014 HI/LO SHALL be written on the same edge where the counter goes 1->0 and busy falls; new values are visible in the first cycle with busy=0.
REQ-015 MULT: {hi,lo} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-016 DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-017 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-018 Divide by zero (b==0, DIV or DIVU): full 10-cycle busy; hi and lo unchanged.
REQ-019 Accept with op 4 (MTHI): hi <= a on that edge; op 5 (MTLO): lo <= a on that edge; busy is not asserted.
REQ-020 start while busy=1: ignored; the in-flight operation and HI/LO are unaffected.
REQ-021 cancel=1: suppresses accept in that cycle; cancel never aborts an already-accepted operation.
REQ-022 Reserved op (6-7) with accept: no state change.
REQ-023 Back-to-back: start on the first cycle with busy=0 SHALL be accepted; that cycle's hi/lo already reflect the previous result.
REQ-024 hi/lo SHALL change only on the edges named in REQ-014, REQ-018, REQ-019 and REQ-025.

Reset
REQ-025 reset=1 at an edge: hi=0, lo=0, busy=0, counter=0, latched operands=0; an in-flight operation is discarded with no HI/LO write.
REQ-026 reset SHALL take priority over start in the same cycle.

Structure
REQ-027 A shared package SHALL hold the op encodings (MDU_MULT..MDU_MTLO) and the latency constants MULT_CYCLES=5 and DIV_CYCLES=10.
REQ-028 No sub-module is required; the result computation is combinational from the latched operands, with a single counter/state register set.
REQ-029 Counter width SHALL be 4 bits; the result mux SHALL be selected by the latched op, not the live op.

Verification
REQ-030 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU on the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-032 MTLO a=0x1234 with cancel=1 -> lo unchanged. Same stimulus with cancel=0 -> lo=0x1234 next cycle; busy stays 0.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start at cycle 2 of busy is ignored.
REQ-034 DIVU b=0 with hi=5, lo=7 -> busy for 10 cycles; hi=5, lo=7 retained.
REQ-035 Reset asserted at busy cycle 3 of a DIV -> next cycle busy=0, hi=0, lo=0. A following MULT 6x7 -> lo=42 after 5 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit_pkg
// Purpose  : Shared definitions for the HI/LO multiply/divide unit. Holds the
//            op encodings, the latency constants and the controller states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

  // Operation encoding on the 3-bit op bus. Codes 6 and 7 are reserved.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int CNT_W = 4;

  // Number of busy cycles after the accepting edge.
  localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [2:0] op_code);
    return (op_code == MDU_DIV) || (op_code == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Fixed-latency multiply/divide unit with HI/LO result registers.
//            MULT/MULTU occupy 5 cycles, DIV/DIVU occupy 10 cycles; MTHI and
//            MTLO write their register directly on the accepting edge.
// Ports    : clk     in   1   rising-edge clock
//            reset   in   1   synchronous, active-high reset
//            start   in   1   E-stage request strobe
//            op      in   3   operation code (see mult_div_unit_pkg)
//            a       in  32   rs operand
//            b       in  32   rt operand
//            cancel  in   1   kill for the E-stage request in this cycle
//            busy    out  1   high while a mult/div is in flight
//            hi      out 32   HI register
//            lo      out 32   LO register
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_lat_q, op_lat_d;
  logic [31:0]      a_lat_q, a_lat_d;
  logic [31:0]      b_lat_q, b_lat_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic             accept;

  // Result datapath: purely combinational from the latched operands/op.
  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic             signed_div;
  logic             div_by_zero;
  logic [31:0]      a_mag;
  logic [31:0]      b_mag;
  logic [31:0]      div_den;
  logic [31:0]      uq;
  logic [31:0]      ur;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s      = {{32{a_lat_q[31]}}, a_lat_q} * {{32{b_lat_q[31]}}, b_lat_q};
    prod_u      = {32'd0, a_lat_q} * {32'd0, b_lat_q};

    // One unsigned divider serves both DIV and DIVU; DIV works on
    // magnitudes and fixes signs afterwards. The magnitude of 0x80000000 is
    // 0x80000000 as an unsigned value, so 0x80000000 / -1 yields 0x80000000.
    signed_div  = (op_lat_q == MDU_DIV);
    div_by_zero = (b_lat_q == 32'd0);
    a_mag       = (signed_div && a_lat_q[31]) ? -a_lat_q : a_lat_q;
    b_mag       = (signed_div && b_lat_q[31]) ? -b_lat_q : b_lat_q;
    // Keep the divider well-defined on a zero divisor; its result is discarded.
    div_den     = div_by_zero ? 32'd1 : b_mag;
    uq          = a_mag / div_den;
    ur          = a_mag % div_den;

    case (op_lat_q)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      default: begin
        // Quotient truncates toward zero; remainder takes the dividend sign.
        res_lo = (signed_div && (a_lat_q[31] ^ b_lat_q[31])) ? -uq : uq;
        res_hi = (signed_div && a_lat_q[31]) ? -ur : ur;
      end
    endcase
  end

  assign accept = start & ~cancel & ~reset & (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_lat_d = op_lat_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              op_lat_d = op;
              a_lat_d  = a;
              b_lat_d  = b;
              cnt_d    = is_div_op(op) ? DIV_CYCLES : MULT_CYCLES;
              state_d  = ST_BUSY;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          // A zero divisor still burns the full latency but leaves HI/LO.
          if (!(is_div_op(op_lat_q) && div_by_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_lat_q <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_lat_q <= op_lat_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit. A transaction-level model
//            computes each result with 64-bit arithmetic when the request is
//            accepted and releases it after the operation latency. Directed
//            cases cover the documented corner values; a random phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: architectural HI/LO, cycles left in flight and the
  // pending result that lands when the count runs out.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_wr = 1'b0;
  int          m_left = 0;

  logic        obs_busy;
  logic [31:0] obs_hi;
  logic [31:0] obs_lo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Effect of one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit s, input logic [2:0] o,
                            input logic [31:0] aa, input logic [31:0] bb, input bit c);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    ua = longint'(aa);
    ub = longint'(bb);
    if (r) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s && !c) begin
      case (o)
        3'd0: begin
          sp = sa * sb;
          {m_phi, m_plo} = sp;
          m_wr = 1'b1;
          m_left = 5;
        end
        3'd1: begin
          up = ua * ub;
          {m_phi, m_plo} = up;
          m_wr = 1'b1;
          m_left = 5;
        end
        3'd2: begin
          m_wr = (bb != 32'd0);
          if (m_wr) begin
            sq = sa / sb;
            sr = sa % sb;
            m_plo = sq[31:0];
            m_phi = sr[31:0];
          end
          m_left = 10;
        end
        3'd3: begin
          m_wr = (bb != 32'd0);
          if (m_wr) begin
            up = ua / ub;
            m_plo = up[31:0];
            up = ua % ub;
            m_phi = up[31:0];
          end
          m_left = 10;
        end
        3'd4: m_hi = aa;
        3'd5: m_lo = aa;
        default: ;
      endcase
    end
  endtask

  // Sample and check outputs at the falling edge, then drive the inputs for
  // the next rising edge and advance the model accordingly.
  task automatic tick(input bit r, input bit s, input logic [2:0] o,
                      input logic [31:0] aa, input logic [31:0] bb, input bit c);
    @(negedge clk);
    obs_busy = busy;
    obs_hi   = hi;
    obs_lo   = lo;
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    reset  = r;
    start  = s;
    op     = o;
    a      = aa;
    b      = bb;
    cancel = c;
    model_step(r, s, o, aa, bb, c);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Issue one op, count busy cycles, then check latency and results against
  // fixed values. poke_at >= 0 fires a competing DIVU start at that busy cycle.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int poke_at);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    tick(1'b0, 1'b1, o, aa, bb, 1'b0);
    for (int k = 0; k < 20 && !done; k++) begin
      tick(1'b0, k == poke_at, 3'd3, 32'h0000DEAD, 32'd3, 1'b0);
      if (obs_busy) cyc++;
      else done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_hi"}, obs_hi, exp_hi);
    chk({tag, "_lo"}, obs_lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);

    // Reset state
    idle();
    chk("rst_busy", 32'(obs_busy), 32'd0);
    chk("rst_hi", obs_hi, 32'd0);
    chk("rst_lo", obs_lo, 32'd0);

    run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, -1);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
    run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, -1);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, -1);

    // Divide by zero keeps HI/LO
    tick(1'b0, 1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 3'd5, 32'd7, 32'd0, 1'b0);
    run_op("divu_z", 3'd3, 32'd9, 32'd0, 10, 32'd5, 32'd7, -1);

    // Reserved op does nothing
    tick(1'b0, 1'b1, 3'd6, 32'hAAAA5555, 32'h12345678, 1'b0);
    idle();
    chk("rsv_busy", 32'(obs_busy), 32'd0);
    chk("rsv_hi", obs_hi, 32'd5);
    chk("rsv_lo", obs_lo, 32'd7);

    // MTLO with and without cancel
    tick(1'b0, 1'b1, 3'd5, 32'h00001234, 32'd0, 1'b1);
    idle();
    chk("mtlo_cancel_lo", obs_lo, 32'd7);
    tick(1'b0, 1'b1, 3'd5, 32'h00001234, 32'd0, 1'b0);
    idle();
    chk("mtlo_lo", obs_lo, 32'h00001234);
    chk("mtlo_busy", 32'(obs_busy), 32'd0);

    // Reset during busy cycle 3 of a DIV
    tick(1'b0, 1'b1, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle();
    idle();
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("rstmid_busy_before", 32'(obs_busy), 32'd1);
    idle();
    chk("rstmid_busy", 32'(obs_busy), 32'd0);
    chk("rstmid_hi", obs_hi, 32'd0);
    chk("rstmid_lo", obs_lo, 32'd0);

    // Reset wins over a simultaneous start
    tick(1'b0, 1'b1, 3'd4, 32'h0000BEEF, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 3'd5, 32'h0000FFFF, 32'd0, 1'b0);
    idle();
    chk("rst_prio_hi", obs_hi, 32'd0);
    chk("rst_prio_lo", obs_lo, 32'd0);

    run_op("mult_6x7", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42, -1);

    // Random phase, including back-to-back starts and occasional reset
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 300) == 0, ($urandom % 2) == 0, 3'($urandom % 8),
           pick_operand(), pick_operand(), ($urandom % 8) == 0);
    end
    repeat (12) idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
